// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use / multiplier stalls,
// an in-flight multiplier scoreboard with a retire hold register, and a stall counter.
module hazard_scoreboard_unit #(
    parameter int MUL_LAT = 4,
    parameter int MUL_FWD = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       RS1__IF_ID,
    input  logic [4:0]       RS2__IF_ID,
    input  logic [4:0]       RD__IF_ID,
    input  logic             WB__IF_ID,
    input  logic [4:0]       RS1__ID_EX,
    input  logic [4:0]       RS2__ID_EX,
    input  logic [4:0]       RD__ID_EX,
    input  logic             WB__ID_EX,
    input  logic             mem_2_reg_ID_EX,
    input  logic             mul_ID_EX,
    input  logic             WB__EX_MEM,
    input  logic             mem_2_reg_EX_MEM,
    input  logic [4:0]       RD__EX_MEM,
    input  logic             WB__MEM_WB,
    input  logic [4:0]       RD__MEM_WB,
    input  logic             perf_clr,
    output logic [1:0]       MUX_A,
    output logic [1:0]       MUX_B,
    output logic             stall,
    output logic             mul_wb_valid,
    output logic [4:0]       mul_wb_rd,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Last scoreboard stage whose result is still too young for a reader in ID.
    localparam int RAW_LAST = (MUL_FWD != 0) ? MUL_LAT - 2 : MUL_LAT - 1;

    logic               push_v;
    logic [MUL_LAT-1:0] sb_valid;
    logic [4:0]         sb_rd [MUL_LAT];
    logic [MUL_LAT-1:0] raw_hit;
    logic [MUL_LAT-1:0] waw_hit;
    logic               hold_v_q;
    logic [4:0]         hold_rd_q;
    logic               hold_fwd;
    logic               load_use;
    logic               ex_mul_hit;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic [1:0]         fwd_sel [2];

    assign push_v = mul_ID_EX & WB__ID_EX & (RD__ID_EX != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
            logic       v_q;
            logic       v_d;
            logic [4:0] rd_q;
            logic [4:0] rd_d;

            if (gi == 0) begin : g_head
                assign v_d  = push_v;
                assign rd_d = RD__ID_EX;
            end else begin : g_tail
                assign v_d  = sb_valid[gi-1];
                assign rd_d = sb_rd[gi-1];
            end

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    v_q  <= 1'b0;
                    rd_q <= 5'd0;
                end else begin
                    v_q  <= v_d;
                    rd_q <= rd_d;
                end
            end

            assign sb_valid[gi] = v_q;
            assign sb_rd[gi]    = rd_q;
            // Valid entries never carry x0, so no separate rd!=0 term is needed.
            assign waw_hit[gi]  = v_q & WB__IF_ID & (rd_q == RD__IF_ID);

            if (gi <= RAW_LAST) begin : g_raw
                assign raw_hit[gi] = v_q & ((rd_q == RS1__IF_ID) | (rd_q == RS2__IF_ID));
            end else begin : g_noraw
                assign raw_hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign mul_wb_valid = sb_valid[MUL_LAT-1];
    assign mul_wb_rd    = sb_rd[MUL_LAT-1];
    assign mul_busy     = |sb_valid;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold_v_q  <= 1'b0;
            hold_rd_q <= 5'd0;
        end else begin
            hold_v_q  <= mul_wb_valid;
            hold_rd_q <= mul_wb_rd;
        end
    end

    assign hold_fwd = (MUL_FWD != 0) & hold_v_q;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [4:0] src;
            logic [1:0] sel;

            assign src = (gi == 0) ? RS1__ID_EX : RS2__ID_EX;

            // A load in EX/MEM has no data yet, so only ALU results forward from there.
            always_comb begin
                sel = 2'b00;
                if (src != 5'd0) begin
                    if (WB__EX_MEM && !mem_2_reg_EX_MEM && (RD__EX_MEM == src)) begin
                        sel = 2'b10;
                    end else if (WB__MEM_WB && (RD__MEM_WB == src)) begin
                        sel = 2'b01;
                    end else if (hold_fwd && (hold_rd_q == src)) begin
                        sel = 2'b11;
                    end
                end
            end

            assign fwd_sel[gi] = sel;
        end
    endgenerate

    assign MUX_A = fwd_sel[0];
    assign MUX_B = fwd_sel[1];

    assign load_use   = mem_2_reg_ID_EX & WB__ID_EX & (RD__ID_EX != 5'd0) &
                        ((RD__ID_EX == RS1__IF_ID) | (RD__ID_EX == RS2__IF_ID));
    assign ex_mul_hit = push_v &
                        ((RD__ID_EX == RS1__IF_ID) | (RD__ID_EX == RS2__IF_ID) |
                         (WB__IF_ID & (RD__ID_EX == RD__IF_ID)));

    assign stall = load_use | ex_mul_hit | (|raw_hit) | (|waw_hit);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter MUL_LAT, 4, multiplier pipeline depth in cycles; legal 1..8.
REQ-002 Parameter MUL_FWD, 1, 1 = forward retired MUL result from the hold register; 0 = stall until the register file is written.
REQ-003 Parameter CNT_W, 16, stall performance counter width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 arst  in  1  asynchronous active-high reset.
REQ-007 RS1__IF_ID, RS2__IF_ID, RD__IF_ID  in  5 each  decode-stage sources and destination.
REQ-008 WB__IF_ID  in  1  decode-stage instruction writes RD__IF_ID.
REQ-009 RS1__ID_EX, RS2__ID_EX, RD__ID_EX  in  5 each  EX-stage sources and destination.
REQ-010 WB__ID_EX, mem_2_reg_ID_EX, mul_ID_EX  in  1 each  EX-stage write enable, load, multiply.
REQ-011 WB__EX_MEM, mem_2_reg_EX_MEM  in  1 each; RD__EX_MEM  in  5.
REQ-012 WB__MEM_WB  in  1; RD__MEM_WB  in  5.
REQ-013 perf_clr  in  1  synchronous clear of stall_cnt.
REQ-014 MUX_A, MUX_B  out  2 each  operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 MUL hold register.
REQ-015 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-016 mul_wb_valid  out  1; mul_wb_rd  out  5  MUL retire write to the dedicated regfile port.
REQ-017 mul_busy  out  1; stall_cnt  out  CNT_W.

Function
REQ-018 Scoreboard: MUL_LAT stages of {valid, rd}; every cycle stage k+1 <= stage k; stage 0 <= {mul_ID_EX & WB__ID_EX & RD__ID_EX!=0, RD__ID_EX}; stall does not block the push.
REQ-019 mul_wb_valid/mul_wb_rd SHALL equal stage MUL_LAT-1 combinationally; mul_busy = OR of all stage valids.
REQ-020 Hold register SHALL load {valid, rd} of stage MUL_LAT-1 every cycle.
REQ-021 A match is valid & rd==source & rd!=0; x0 never matches, forwards or stalls.
REQ-022 Forward rs1/rs2 of ID_EX, priority high to low: EX/MEM (WB & ~mem_2_reg) -> 10; MEM/WB (WB) -> 01; hold register (MUL_FWD=1 only) -> 11; else 00.
REQ-023 stall SHALL be asserted if any of: load-use (mem_2_reg_ID_EX & WB__ID_EX & RD__ID_EX matches RS1/RS2__IF_ID); EX MUL (mul_ID_EX & WB__ID_EX) whose RD matches RS1/RS2/RD(with WB__IF_ID) of IF_ID; an IF_ID source matching scoreboard stage k, k <= MUL_LAT-2 (MUL_FWD=1) or k <= MUL_LAT-1 (MUL_FWD=0).
REQ-024 WAW: an IF_ID instruction with WB__IF_ID whose RD matches any valid scoreboard stage SHALL stall, regardless of MUL_FWD.
REQ-025 MUL_FWD=1 latency: consumer leaves ID the cycle its producer sits in stage MUL_LAT-1 and receives 11 in EX next cycle; MUL_FWD=0: one cycle later, select 00.
REQ-026 stall_cnt increments by 1 each cycle stall=1, saturates at all-ones; perf_clr wins over increment.
REQ-027 MUX_A, MUX_B, stall SHALL be purely combinational from inputs and registered state.

Reset
REQ-028 On arst: all scoreboard valids, hold valid and stall_cnt cleared to 0 immediately; hence mul_wb_valid=0, mul_busy=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight MUL entries with no retire pulse; first push after release enters stage 0.

Verification
REQ-030 MUL_LAT=4, MUL_FWD=1: MUL x5 in EX, dependent add x6=x5+x1 in ID -> stall high 4 cycles, then MUX_A=11 in the add's EX cycle; mul_wb_valid=1, mul_wb_rd=5 one cycle earlier.
REQ-031 Same with MUL_FWD=0 -> stall high 5 cycles, MUX_A=00; stall_cnt=5.
REQ-032 Load x3 in EX, consumer of x3 in ID -> one-cycle stall; next cycle MUX=01 from MEM/WB, never 10 from a load in EX/MEM.
REQ-033 EX/MEM and MEM/WB both write x7, consumer rs2=x7 -> MUX_B=10; rd=x0 everywhere -> MUX=00, stall=0.
REQ-034 MUL x9 in stage 1, ID instruction writes x9 (WAW) -> stall until stage clear; stall_cnt saturates at 2^CNT_W-1 with CNT_W=4 after 20 stall cycles; perf_clr -> 0.
REQ-035 arst pulsed with 3 MULs in flight -> mul_busy=0 same cycle, no mul_wb_valid pulse afterwards.
